// File: rtl/readout_unit_if.sv
// BRAM read port plus valid/ready result stream between the readout sequencer and its neighbours.
interface readout_unit_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output rd_en, rd_address, out_data, out_valid, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_address, out_data, out_valid, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/readout_unit.sv
// Read-side sequencer: on a compute_ready rising edge, streams every BRAM word
// in ascending order over valid/ready, flagging the last word, then pulses done.
module readout_unit #(
    parameter int BRAM_DEPTH = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          compute_ready,
    readout_unit_if.master bus,
    output logic          busy,
    output logic          done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BRAM_DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  cr_q;
    logic                  rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  start;

    assign start = compute_ready & ~cr_q & (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_en_d     = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    rd_en_d = 1'b1;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                // rd_data now reflects the address presented during FETCH
                state_d     = S_HOLD;
                out_data_d  = bus.rd_data;
                out_valid_d = 1'b1;
                out_last_d  = (cnt_q == LAST_ADDR);
            end
            S_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        cnt_d   = cnt_q + 1'b1;
                        rd_en_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Status flags track the next state so they move on the same edge as it
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cr_q        <= 1'b0;
            rd_en_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cr_q        <= compute_ready;
            rd_en_q     <= rd_en_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.rd_address = cnt_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_readout_unit.sv
// Bench for readout_unit: depth-2 and depth-1 instances, BRAM models, and a
// pass-level reference (every address in order, last flag on the final word).
module tb_readout_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, cr1, cr2;
    logic busy1, done1, busy2, done2;

    readout_unit_if #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) b1 ();
    readout_unit_if #(.ADDR_WIDTH(1), .DATA_WIDTH(16)) b2 ();

    readout_unit #(.BRAM_DEPTH(2), .ADDR_WIDTH(2), .DATA_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .compute_ready(cr1), .bus(b1), .busy(busy1), .done(done1)
    );
    readout_unit #(.BRAM_DEPTH(1), .ADDR_WIDTH(1), .DATA_WIDTH(16)) dut2 (
        .clk(clk), .reset(reset), .compute_ready(cr2), .bus(b2), .busy(busy2), .done(done2)
    );

    logic [15:0] mem1 [0:3];
    logic [15:0] mem2 [0:1];
    always @(posedge clk) if (b1.rd_en) b1.rd_data <= mem1[b1.rd_address];
    always @(posedge clk) if (b2.rd_en) b2.rd_data <= mem2[b2.rd_address];

    int checks = 0;
    int errors = 0;

    // Transaction logs gathered at the falling edge
    int          cyc = 0;
    int          addr_log [$];
    logic [15:0] w_log [$];
    logic        l_log [$];
    int          hs_cyc [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          viol = 0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [15:0] pd = '0;
    logic [15:0] w2_log [$];
    logic        l2_log [$];
    int          hs2_cyc = 0;
    int          done2_cnt = 0;
    int          done2_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (b1.rd_en === 1'b1) addr_log.push_back(int'(b1.rd_address));
        if (b1.out_valid === 1'b1 && b1.out_ready === 1'b1) begin
            w_log.push_back(b1.out_data);
            l_log.push_back(b1.out_last);
            hs_cyc.push_back(cyc);
        end
        if (done1 === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (reset === 1'b1 && pv && !pr && (b1.out_valid !== 1'b1 || b1.out_data !== pd)) viol++;
        pv = (b1.out_valid === 1'b1);
        pr = (b1.out_ready === 1'b1);
        pd = b1.out_data;
        if (b2.out_valid === 1'b1 && b2.out_ready === 1'b1) begin
            w2_log.push_back(b2.out_data);
            l2_log.push_back(b2.out_last);
            hs2_cyc = cyc;
        end
        if (done2 === 1'b1) begin
            done2_cnt++;
            done2_cyc = cyc;
        end
    end

    int ba = 0, bw = 0, bd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mark;
        ba = addr_log.size();
        bw = w_log.size();
        bd = done_cnt;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done1 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done1), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy1), 32'd1);
        tick();
        chk({tag, "_done_pulse_end"}, 32'(done1), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy1), 32'd0);
    endtask

    // Reference pass: addresses 0..1 in order, words equal mem contents, last on address 1
    task automatic check_pass(input string tag);
        repeat (2) tick();
        chk({tag, "_n_reads"}, 32'(addr_log.size() - ba), 32'd2);
        chk({tag, "_n_words"}, 32'(w_log.size() - bw), 32'd2);
        chk({tag, "_n_done"}, 32'(done_cnt - bd), 32'd1);
        for (int i = 0; i < 2; i++) begin
            if (addr_log.size() > ba + i)
                chk($sformatf("%s_addr%0d", tag, i), 32'(addr_log[ba + i]), 32'(i));
            if (w_log.size() > bw + i) begin
                chk($sformatf("%s_word%0d", tag, i), 32'(w_log[bw + i]), 32'(mem1[i]));
                chk($sformatf("%s_last%0d", tag, i), 32'(l_log[bw + i]), 32'(i == 1));
            end
        end
        $display("pass %s: reads=%0d words=%0d dones=%0d", tag,
                 addr_log.size() - ba, w_log.size() - bw, done_cnt - bd);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; cr1 = 1'b0; cr2 = 1'b0;
        b1.out_ready = 1'b0; b2.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) mem1[i] = '0;
        mem2[0] = '0; mem2[1] = '0;
        repeat (3) tick();
        chk("rst_rd_en", 32'(b1.rd_en), 32'd0);
        chk("rst_rd_addr", 32'(b1.rd_address), 32'd0);
        chk("rst_out_data", 32'(b1.out_data), 32'd0);
        chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
        chk("rst_out_last", 32'(b1.out_last), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst2_valid", 32'(b2.out_valid), 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Directed pass with fixed contents and exact timing
        mem1[0] = 16'hA5A5; mem1[1] = 16'h5A5A; b1.out_ready = 1'b1;
        mark();
        cr1 = 1'b1; tick();
        chk("E0_rd_en", 32'(b1.rd_en), 32'd1);
        chk("E0_rd_addr", 32'(b1.rd_address), 32'd0);
        chk("E0_busy", 32'(busy1), 32'd1);
        cr1 = 1'b0; tick();
        chk("E1_rd_en", 32'(b1.rd_en), 32'd0);
        chk("E1_valid", 32'(b1.out_valid), 32'd0);
        tick();
        chk("E2_valid", 32'(b1.out_valid), 32'd1);
        chk("E2_data", 32'(b1.out_data), 32'hA5A5);
        chk("E2_last", 32'(b1.out_last), 32'd0);
        wait_done("B");
        check_pass("B");
        if (hs_cyc.size() > bw + 1) begin
            chk("B_spacing", 32'(hs_cyc[bw + 1] - hs_cyc[bw]), 32'd3);
            chk("B_done_lag", 32'(done_cyc - hs_cyc[bw + 1]), 32'd1);
        end

        // Backpressure in HOLD
        b1.out_ready = 1'b0;
        mark();
        cr1 = 1'b1; tick(); cr1 = 1'b0;
        n = 0;
        while (b1.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        chk("C_valid_seen", 32'(b1.out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("C_hold_data%0d", k), 32'(b1.out_data), 32'hA5A5);
            chk($sformatf("C_hold_valid%0d", k), 32'(b1.out_valid), 32'd1);
            chk($sformatf("C_hold_rd_en%0d", k), 32'(b1.rd_en), 32'd0);
        end
        b1.out_ready = 1'b1;
        wait_done("C");
        check_pass("C");

        // compute_ready held high: one pass only, then a fresh edge repeats it
        mem1[0] = 16'($urandom); mem1[1] = 16'($urandom);
        mark();
        cr1 = 1'b1; repeat (50) tick(); cr1 = 1'b0;
        check_pass("D1");
        mark();
        cr1 = 1'b1; tick(); cr1 = 1'b0;
        wait_done("D2");
        check_pass("D2");

        // Rising edge while busy is ignored
        mem1[0] = 16'($urandom); mem1[1] = 16'($urandom);
        mark();
        cr1 = 1'b1; tick(); cr1 = 1'b0; tick(); tick();
        cr1 = 1'b1; tick(); cr1 = 1'b0;
        wait_done("E");
        repeat (5) tick();
        check_pass("E");

        // Randomized contents and consumer readiness
        for (int p = 0; p < 4; p++) begin
            mem1[0] = 16'($urandom); mem1[1] = 16'($urandom);
            mark();
            cr1 = 1'b1; tick(); cr1 = 1'b0;
            n = 0;
            while (done1 !== 1'b1 && n < 300) begin
                b1.out_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            chk($sformatf("F%0d_done_seen", p), 32'(done1), 32'd1);
            b1.out_ready = 1'b1;
            check_pass($sformatf("F%0d", p));
        end

        // Asynchronous reset mid-cycle while holding a word
        b1.out_ready = 1'b0;
        cr1 = 1'b1; tick(); cr1 = 1'b0;
        n = 0;
        while (b1.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        chk("G_valid_seen", 32'(b1.out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("G_rd_en", 32'(b1.rd_en), 32'd0);
        chk("G_rd_addr", 32'(b1.rd_address), 32'd0);
        chk("G_out_data", 32'(b1.out_data), 32'd0);
        chk("G_out_valid", 32'(b1.out_valid), 32'd0);
        chk("G_out_last", 32'(b1.out_last), 32'd0);
        chk("G_busy", 32'(busy1), 32'd0);
        chk("G_done", 32'(done1), 32'd0);
        mark();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) tick();
        chk("G_idle_reads", 32'(addr_log.size() - ba), 32'd0);
        chk("G_idle_words", 32'(w_log.size() - bw), 32'd0);
        chk("G_idle_busy", 32'(busy1), 32'd0);

        // compute_ready already high at reset release starts a pass
        @(negedge clk) reset = 1'b0;
        cr1 = 1'b1; b1.out_ready = 1'b1;
        mem1[0] = 16'($urandom); mem1[1] = 16'($urandom);
        @(negedge clk);
        mark();
        reset = 1'b1;
        tick();
        chk("G2_rd_en", 32'(b1.rd_en), 32'd1);
        cr1 = 1'b0;
        wait_done("G2");
        check_pass("G2");

        // Single-word BRAM
        mem2[0] = 16'($urandom);
        b2.out_ready = 1'b1;
        cr2 = 1'b1; tick(); cr2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 50) begin tick(); n++; end
        chk("H_done_seen", 32'(done2), 32'd1);
        repeat (2) tick();
        chk("H_n_words", 32'(w2_log.size()), 32'd1);
        if (w2_log.size() > 0) begin
            chk("H_word", 32'(w2_log[0]), 32'(mem2[0]));
            chk("H_last", 32'(l2_log[0]), 32'd1);
        end
        chk("H_n_done", 32'(done2_cnt), 32'd1);
        chk("H_done_lag", 32'(done2_cyc - hs2_cyc), 32'd1);
        chk("H_busy_end", 32'(busy2), 32'd0);
        $display("pass H: words=%0d dones=%0d", w2_log.size(), done2_cnt);

        chk("valid_no_drop", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/readout_unit.md
# readout_unit

Read-side sequencer for the compute BRAM, the counterpart of `control_unit`. `control_unit` fills the BRAM and raises `compute_ready`. This block then reads every BRAM location in ascending address order and presents each word on a valid/ready output stream, marking the last word. It sits between the BRAM read port and the downstream result consumer.

## Interface
- `BRAM_DEPTH`, default 2: number of words to read per pass (≥1).
- `ADDR_WIDTH`, default 2: width of `rd_address`. Must satisfy 2^ADDR_WIDTH ≥ BRAM_DEPTH.
- `DATA_WIDTH`, default 16: BRAM word width.
- `clk` in, 1: the single clock. All logic is rising-edge.
- `reset` in, 1: asynchronous, active-low reset.
- `compute_ready` in, 1: from `control_unit`. Its rising edge starts one readout pass.
- `rd_en` out, 1: BRAM read enable.
- `rd_address` out, ADDR_WIDTH: BRAM read address.
- `rd_data` in, DATA_WIDTH: BRAM read data, valid one cycle after the edge that samples `rd_en`/`rd_address`.
- `out_data` out, DATA_WIDTH: current output word.
- `out_valid` out, 1: `out_data` is valid.
- `out_ready` in, 1: consumer accepts the word.
- `out_last` out, 1: current word is from address BRAM_DEPTH-1.
- `busy` out, 1: a pass is in progress.
- `done` out, 1: one-cycle pulse when a pass completes.

## Operation
- Start detection:
  - `cr_q` registers `compute_ready`; its reset value is 0.
  - start = `compute_ready` & ~`cr_q` & (state==IDLE).
  - A rising edge outside IDLE is ignored.
  - `compute_ready` held high does not restart the block.
- FSM states: IDLE, FETCH, WAIT, HOLD, DONE.
  - IDLE: start → FETCH, with the address counter set to 0.
  - FETCH: `rd_en`=1 and `rd_address`=counter. Always → WAIT.
  - WAIT: `rd_en`=0. Always → HOLD, with `out_data`<=`rd_data`, `out_valid`<=1, and `out_last`<=(counter==BRAM_DEPTH-1).
  - HOLD:
    - `out_data`, `out_valid` and `out_last` stay stable while `out_ready`=0.
    - On `out_valid`&`out_ready`: `out_valid`<=0 and `out_last`<=0.
    - Then, if the counter is not the last address: counter+1 → FETCH.
    - If the counter is the last address: → DONE.
  - DONE: `done`=1 for exactly one cycle, then → IDLE.
- `busy` = (state != IDLE). It is registered and changes on the same edge as the state.
- The counter is ADDR_WIDTH wide and never exceeds BRAM_DEPTH-1. There is no wrap within a pass; it resets to 0 on each start.
- The consumer must not see `out_valid` drop without a handshake.
- Reset (asynchronous, any state):
  - State → IDLE.
  - `rd_en`=0, `rd_address`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `cr_q`=0.
  - A partially delivered pass is abandoned, not resumed.
  - If `compute_ready` is already high at reset release, the first sampled edge counts as a rising edge and starts a pass.

## Timing
- Let E0 be the edge that samples start.
  - After E0: `rd_en`=1, `rd_address`=0, `busy`=1.
  - After E1: `rd_en`=0. The BRAM has sampled address 0.
  - After E2: `out_valid`=1 and `out_data`=word[0].
- Start-to-first-valid latency is 2 cycles.
- Per word with `out_ready` tied high: 3 cycles (FETCH, WAIT, HOLD).
  - The handshake edge in HOLD is followed immediately by FETCH of the next address.
- Last handshake at edge Ek: after Ek `done`=1 and `busy`=1; after Ek+1 `done`=0 and `busy`=0.
  - A new start can be sampled at Ek+2 at the earliest (IDLE present after Ek+1).
- `out_ready` is only evaluated in HOLD. `out_ready` high in any other state has no effect.
- BRAM_DEPTH=1: the single word has `out_last`=1, and the pass is FETCH, WAIT, HOLD, DONE.

## Test plan
- BRAM_DEPTH=2, BRAM preloaded with 0xA5A5 at address 0 and 0x5A5A at address 1, `out_ready`=1, pulse `compute_ready` → expect:
  - `rd_en` at addresses 0 then 1;
  - `out_data` 0xA5A5 (`out_last`=0), then 0x5A5A (`out_last`=1);
  - valids 3 cycles apart;
  - `done` pulse 1 cycle after the last handshake.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD → `out_data` stays 0xA5A5, `out_valid` stays 1, and `rd_en` stays 0. Release → sequence resumes with address 1.
- `compute_ready` held high for 50 cycles → exactly one pass and one `done` pulse. A second rising edge after `busy`=0 → a second identical pass.
- A `compute_ready` rising edge while `busy`=1 → ignored; exactly 2 words are delivered.
- Assert `reset`=0 asynchronously (mid-clock) while in HOLD → all outputs 0 immediately. After release with `compute_ready` low, the block stays IDLE with no `rd_en`.
- BRAM_DEPTH=1 → one word with `out_last`=1, then `done`.
